// File: rtl/timer_pkg.sv
// Shared types and constants for the mm:ss countdown timer.
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  typedef logic [3:0] digit_t;

  localparam digit_t DIGIT_MAX = 4'd9;
  localparam digit_t TENS_WRAP = 4'd5;

  function automatic logic digit_ok(input digit_t d);
    return (d <= DIGIT_MAX);
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit of the count: keypad shift, borrow-chained decrement, soft clear.
module bcd_digit
  import timer_pkg::*;
#(
  parameter digit_t WRAP = DIGIT_MAX
) (
  input  logic   clk,
  input  logic   clr,
  input  logic   srst,
  input  digit_t shift_in,
  input  logic   load,
  input  logic   dec_en,
  input  logic   borrow_in,
  output logic   borrow_out,
  output logic   is_zero,
  output digit_t value
);

  digit_t digit_r;

  // Digit register: clear beats shift, shift beats decrement.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      digit_r <= 4'd0;
    end else if (srst) begin
      digit_r <= 4'd0;
    end else if (load) begin
      digit_r <= shift_in;
    end else if (dec_en && borrow_in) begin
      if (digit_r == 4'd0) begin
        digit_r <= WRAP;
      end else begin
        digit_r <= digit_r - 4'd1;
      end
    end else begin
      digit_r <= digit_r;
    end
  end

  assign is_zero    = (digit_r == 4'd0);
  assign borrow_out = borrow_in & is_zero;
  assign value      = digit_r;

endmodule

// File: rtl/mmss_timer.sv
// Keypad-loaded mm:ss countdown timer with run/pause/cancel control.
module mmss_timer
  import timer_pkg::*;
#(
  parameter int MIN_DIGITS = 1
) (
  input  logic                    clk,
  input  logic                    clr,
  input  logic [3:0]              data,
  input  logic                    load,
  input  logic                    start,
  input  logic                    pause,
  input  logic                    cancel,
  input  logic                    tick,
  output logic [3:0]              sec_ones,
  output logic [3:0]              sec_tens,
  output logic [4*MIN_DIGITS-1:0] mins,
  output logic                    zero,
  output logic                    running,
  output logic                    done,
  output logic [1:0]              state
);

  state_t                state_r;
  logic                  running_r;
  logic                  done_r;
  logic                  load_ok_s;
  logic                  dec_en_s;
  logic                  one_left_s;
  logic                  zero_s;
  digit_t                ones_val_s;
  digit_t                tens_val_s;
  logic                  ones_zero_s;
  logic                  tens_zero_s;
  logic                  ones_borrow_s;
  digit_t                min_val_s  [MIN_DIGITS];
  logic [MIN_DIGITS-1:0] min_zero_s;
  logic [MIN_DIGITS:0]   min_borrow_s;

  // The borrow chain starts at 1, so the final borrow-out means every digit is zero.
  assign zero_s     = min_borrow_s[MIN_DIGITS];
  assign one_left_s = !ones_zero_s && (ones_val_s[3:1] == 3'd0) && tens_zero_s && (&min_zero_s);
  assign dec_en_s   = tick && (state_r == ST_RUN) && !cancel;

  // Keypad entry gate: only in IDLE/DONE, and a successful start in IDLE takes the cycle.
  always_comb begin
    load_ok_s = 1'b0;
    if (cancel) begin
      load_ok_s = 1'b0;
    end else if (load && digit_ok(data)) begin
      case (state_r)
        ST_IDLE: load_ok_s = !(start && !zero_s);
        ST_DONE: load_ok_s = 1'b1;
        default: load_ok_s = 1'b0;
      endcase
    end else begin
      load_ok_s = 1'b0;
    end
  end

  bcd_digit #(.WRAP(DIGIT_MAX)) u_sec_ones (
    .clk(clk), .clr(clr), .srst(cancel), .shift_in(data), .load(load_ok_s),
    .dec_en(dec_en_s), .borrow_in(1'b1), .borrow_out(ones_borrow_s),
    .is_zero(ones_zero_s), .value(ones_val_s)
  );

  bcd_digit #(.WRAP(TENS_WRAP)) u_sec_tens (
    .clk(clk), .clr(clr), .srst(cancel), .shift_in(ones_val_s), .load(load_ok_s),
    .dec_en(dec_en_s), .borrow_in(ones_borrow_s), .borrow_out(min_borrow_s[0]),
    .is_zero(tens_zero_s), .value(tens_val_s)
  );

  for (genvar i = 0; i < MIN_DIGITS; i++) begin : g_min
    digit_t shift_s;
    if (i == 0) begin : g_first
      assign shift_s = tens_val_s;
    end else begin : g_rest
      assign shift_s = min_val_s[i-1];
    end

    bcd_digit #(.WRAP(DIGIT_MAX)) u_min (
      .clk(clk), .clr(clr), .srst(cancel), .shift_in(shift_s), .load(load_ok_s),
      .dec_en(dec_en_s), .borrow_in(min_borrow_s[i]), .borrow_out(min_borrow_s[i+1]),
      .is_zero(min_zero_s[i]), .value(min_val_s[i])
    );

    assign mins[4*i +: 4] = min_val_s[i];
  end

  // Control FSM; priority cancel > tick-to-zero > pause > start > load.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_r   <= ST_IDLE;
      running_r <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (cancel) begin
        state_r   <= ST_IDLE;
        running_r <= 1'b0;
      end else begin
        case (state_r)
          ST_RUN: begin
            if (tick && one_left_s) begin
              state_r   <= ST_DONE;
              running_r <= 1'b0;
              done_r    <= 1'b1;
            end else if (pause) begin
              state_r   <= ST_PAUSED;
              running_r <= 1'b0;
            end else begin
              state_r   <= ST_RUN;
              running_r <= 1'b1;
            end
          end
          ST_IDLE: begin
            if (start && !zero_s) begin
              state_r   <= ST_RUN;
              running_r <= 1'b1;
            end else begin
              state_r   <= ST_IDLE;
              running_r <= 1'b0;
            end
          end
          ST_PAUSED: begin
            if (start) begin
              state_r   <= ST_RUN;
              running_r <= 1'b1;
            end else begin
              state_r   <= ST_PAUSED;
              running_r <= 1'b0;
            end
          end
          ST_DONE: begin
            if (load_ok_s) begin
              state_r <= ST_IDLE;
            end else begin
              state_r <= ST_DONE;
            end
            running_r <= 1'b0;
          end
          default: begin
            state_r   <= ST_IDLE;
            running_r <= 1'b0;
          end
        endcase
      end
    end
  end

  assign sec_ones = ones_val_s;
  assign sec_tens = tens_val_s;
  assign zero     = zero_s;
  assign running  = running_r;
  assign done     = done_r;
  assign state    = state_r;

endmodule

// File: doc/mmss_timer.md
MMSS_TIMER -- requirements
Module: mmss_timer

Interface
REQ-001 Parameter MIN_DIGITS, default 1, number of BCD minute digits (legal 1..3).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 clr  input  1  asynchronous active-high reset.
REQ-004 data  input  4  keypad digit to enter.
REQ-005 load  input  1  one-cycle strobe; shift data into the count.
REQ-006 start  input  1  one-cycle strobe; begin or resume countdown.
REQ-007 pause  input  1  one-cycle strobe; suspend countdown.
REQ-008 cancel  input  1  one-cycle strobe; abort and zero the count.
REQ-009 tick  input  1  one-cycle 1 Hz strobe; one second elapsed.
REQ-010 sec_ones  output  4  BCD seconds units.
REQ-011 sec_tens  output  4  BCD seconds tens, 0..9 (entries such as 1:90 are legal).
REQ-012 mins  output  4*MIN_DIGITS  BCD minutes, least significant digit in bits [3:0].
REQ-013 zero  output  1  high when every digit is 0.
REQ-014 running  output  1  high in state RUN.
REQ-015 done  output  1  one-cycle pulse on completion.
REQ-016 state  output  2  current FSM state (IDLE=0, RUN=1, PAUSED=2, DONE=3).

Function
REQ-017 Every output shall be registered or decoded only from registers; there is no combinational input-to-output path.
REQ-018 Load in IDLE or DONE with data<=9 shall shift the digits on the next edge: mins shifted up one digit (top minute digit discarded), sec_tens->mins[3:0], sec_ones->sec_tens, data->sec_ones.
REQ-019 Load with data>9 shall be ignored; load in RUN or PAUSED shall be ignored.
REQ-020 Load in DONE shall also move the FSM to IDLE.
REQ-021 IDLE + start with zero=0 shall go to RUN; IDLE + start with zero=1 shall stay in IDLE.
REQ-022 A tick in RUN shall decrement the count by one second on the same edge.
REQ-023 Decrement: sec_ones 0 -> 9 with borrow; sec_tens 0 -> 5 with borrow; sec_tens 1..9 -> value-1; each minute digit 0 -> 9 with borrow into the next.
REQ-024 A tick that reaches all-zero shall enter DONE and assert done for exactly that cycle.
REQ-025 RUN + pause shall go to PAUSED; a tick in the same cycle shall still decrement, and if it reaches zero the FSM shall go to DONE instead.
REQ-026 PAUSED + start shall return to RUN; ticks in PAUSED, IDLE and DONE shall be ignored.
REQ-027 cancel in any state shall clear all digits and enter IDLE, overriding every other input in that cycle.
REQ-028 Priority per cycle: cancel > tick-to-zero > pause > start > load.
REQ-029 DONE shall hold the count at zero; start in DONE shall be ignored.

Reset
REQ-030 While clr=1: all digits 0, state IDLE, done 0, running 0, zero 1.
REQ-031 clr asserted mid-countdown shall abort immediately, without waiting for an edge; the first edge after release shall behave as IDLE.

Structure
REQ-032 A shared package timer_pkg shall hold the state enum, the 4-bit digit type, and the constants DIGIT_MAX=9 and TENS_WRAP=5.
REQ-033 Each digit shall be one instance of sub-module bcd_digit with the following ports and behaviour:
- ports: wrap-value parameter, shift-in, load, decrement-enable, borrow-in, borrow-out, is-zero;
- instances: sec_ones, sec_tens and MIN_DIGITS minute digits, generated.
REQ-034 The FSM and the priority decode shall live in mmss_timer.

Verification
REQ-035 Reset, then load 1, 3, 0 -> sec_ones=0, sec_tens=3, mins=1, state IDLE, zero=0.
REQ-036 From 1:30, start then 31 ticks -> count 0:59, running=1.
REQ-037 Load 9, 0 (0:90), start, 1 tick -> 0:89; run to zero -> done pulses for exactly one cycle and state DONE.
REQ-038 From 0:05 in RUN, pause with tick in the same cycle -> 0:04, state PAUSED; further ticks leave 0:04; start -> RUN.
REQ-039 From 0:01 in RUN, pause and tick in the same cycle -> 0:00, state DONE, done=1; cancel with tick in RUN -> 0:00, state IDLE, done=0.
REQ-040 Start from zero -> stays in IDLE; load data=12 -> no change; clr asserted between clock edges in RUN -> outputs reset before the next edge.
